// File: rtl/jtag_cmd_arb.sv
// jtag_cmd_arb
// Two-port command arbiter and sequencer for the JTAG shift engine.
// Port 0 (VME slave) has fixed priority. Port 1 (configuration loader) is
// forced through after MAX_CONSEC back-to-back port-0 grants made while it
// was waiting. Each granted command runs through SETUP -> STRB -> WAIT_DT ->
// REL -> DONE. DONE issues a one-cycle ACK, with ERR set if the DTACK or
// busy-release wait timed out.
//
// Ports
//   FASTCLK, clr_pload      clock, async active-high reset
//   SLOWCLK_EN              engine slow-clock edge enable
//   REQ0/1, CMD0/1, DIN0/1  requester side
//   DTACK_B, JBUSY_B, JDOUT engine handshake and read-back
//   COMMAND, INDATA         command/data presented to the engine
//   STROBE, STRBCE          engine strobe and one-cycle strobe-edge enable
//   ACK0/1, ERR             completion pulses
//   RDATA                   TDO read-back from the last opcode-5 command
//   GNT, ARB_BUSY           granted port index, busy from grant through ACK
module jtag_cmd_arb #(
  parameter int               TMO_W      = 16,
  parameter logic [TMO_W-1:0] TMO_MAX    = 16'hFFF0,
  parameter int               MAX_CONSEC = 4
) (
  input  logic        FASTCLK,
  input  logic        clr_pload,
  input  logic        SLOWCLK_EN,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [9:0]  CMD0,
  input  logic [9:0]  CMD1,
  input  logic [15:0] DIN0,
  input  logic [15:0] DIN1,
  input  logic        DTACK_B,
  input  logic        JBUSY_B,
  input  logic [15:0] JDOUT,
  output logic [9:0]  COMMAND,
  output logic [15:0] INDATA,
  output logic        STROBE,
  output logic        STRBCE,
  output logic        ACK0,
  output logic        ACK1,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic        GNT,
  output logic        ARB_BUSY
);

  typedef enum logic [2:0] {IDLE, SETUP, STRB, WAIT_DT, REL, DONE} state_t;

  localparam logic [2:0]       MAXC     = 3'(MAX_CONSEC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - 1'b1;

  state_t           state;
  logic [2:0]       consec;
  logic [TMO_W-1:0] tmo;
  logic             hi_seen;  // JBUSY_B was high on the previous SLOWCLK_EN
  logic             err_lat;

  logic tmo_hit, win1, rel_ok;

  // Counter starts at 0 on state entry, so hitting TMO_MAX-1 means the
  // current cycle is the TMO_MAX-th one spent in the state.
  assign tmo_hit = (tmo >= TMO_LAST);
  assign win1    = REQ1 & (~REQ0 | (consec == MAXC));
  assign rel_ok  = SLOWCLK_EN & JBUSY_B & hi_seen;

  always_ff @(posedge FASTCLK or posedge clr_pload) begin
    if (clr_pload) begin
      state    <= IDLE;
      consec   <= '0;
      tmo      <= '0;
      hi_seen  <= 1'b0;
      err_lat  <= 1'b0;
      COMMAND  <= '0;
      INDATA   <= '0;
      STROBE   <= 1'b0;
      STRBCE   <= 1'b0;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      ERR      <= 1'b0;
      RDATA    <= '0;
      GNT      <= 1'b0;
      ARB_BUSY <= 1'b0;
    end else begin
      STRBCE <= 1'b0;
      ACK0   <= 1'b0;
      ACK1   <= 1'b0;
      ERR    <= 1'b0;
      case (state)
        IDLE: begin
          if (!REQ1) consec <= '0;
          if (REQ0 | REQ1) begin
            GNT      <= win1;
            ARB_BUSY <= 1'b1;
            err_lat  <= 1'b0;
            COMMAND  <= win1 ? CMD1 : CMD0;
            INDATA   <= win1 ? DIN1 : DIN0;
            if (win1) consec <= '0;
            else if (REQ1 && consec != 3'd7) consec <= consec + 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          STROBE <= 1'b1;
          STRBCE <= 1'b1;
          state  <= STRB;
        end
        STRB: begin
          tmo   <= '0;
          state <= WAIT_DT;
        end
        WAIT_DT: begin
          if (!DTACK_B || tmo_hit) begin
            if (!DTACK_B && COMMAND[5:0] == 6'd5) RDATA <= JDOUT;
            if (DTACK_B) err_lat <= 1'b1;
            STROBE  <= 1'b0;
            tmo     <= '0;
            hi_seen <= 1'b0;
            state   <= REL;
          end else if (tmo != '1) begin
            tmo <= tmo + 1'b1;
          end
        end
        REL: begin
          if (rel_ok || tmo_hit) begin
            ACK0  <= ~GNT;
            ACK1  <= GNT;
            ERR   <= err_lat | (tmo_hit & ~rel_ok);
            state <= DONE;
          end else begin
            if (tmo != '1) tmo <= tmo + 1'b1;
            if (SLOWCLK_EN) hi_seen <= JBUSY_B;
          end
        end
        DONE: begin
          ARB_BUSY <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
